wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Schedules the single architectural register-file write port between the ALU, LSU, MUL and DIV completion paths.
- Sits between the EXE units and the issue stage's register file / scoreboard-clear input.
- ALU/LSU/MUL are fixed-latency and collision-free by issue-time scheduling; DIV completes at an unpredictable time, so its results are buffered and slotted into idle write cycles.
- If a DIV result starves, the block forces an issue bubble.

Parameters:
- REG_WIDTH, 5, register index width
- DATA_WIDTH, 32, write data width
- DIV_Q_DEPTH, 2, DIV result buffer entries (power of two, >=2)
- STARVE_LIMIT, 4, cycles a buffered DIV result may wait before forcing an issue bubble

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- flush  in  1  branch redirect; drops DIV results (always younger than the branch)
- alu_wb_valid  in  1  ALU result valid
- alu_wb_rd  in  REG_WIDTH  ALU destination
- alu_wb_data  in  DATA_WIDTH  ALU result
- lsu_wb_valid / lsu_wb_rd / lsu_wb_data  in  1 / REG_WIDTH / DATA_WIDTH  LSU result
- mul_wb_valid / mul_wb_rd / mul_wb_data  in  1 / REG_WIDTH / DATA_WIDTH  MUL result
- div_wb_valid  in  1  DIV result offered
- div_wb_ready  out  1  DIV result accepted when valid&&ready
- div_wb_rd / div_wb_data  in  REG_WIDTH / DATA_WIDTH  DIV result
- wb_wr_en  out  1  register-file write enable (registered)
- wb_rd  out  REG_WIDTH  write index (registered)
- wb_data  out  DATA_WIDTH  write data (registered)
- ix_wb_stall  out  1  request issue stage to insert a bubble
- collision_err  out  1  sticky: two fixed-latency results arrived in one cycle
- div_q_count  out  $clog2(DIV_Q_DEPTH)+1  buffered DIV entries

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, buffer empty, starve counter 0, FSM=IDLE; div_wb_ready=0 while in reset.
- Latency: the winning result sampled at edge N appears on wb_* after edge N (one register stage); no combinational input-to-wb path.
- Fixed-unit priority: MUL > LSU > ALU. If two or more fixed units are valid in one cycle, only the highest is written, the others are dropped, and collision_err sets; it clears only on reset.
- The DIV path is written only in a cycle with no fixed-unit valid.
  - Source is the buffer head if non-empty; otherwise a DIV handshake accepted this cycle is written directly (bypass) without entering the buffer.
  - A DIV result accepted in a cycle that is occupied (fixed unit valid, or buffer non-empty) is pushed to the buffer tail.
  - Head pop and tail push may occur in the same cycle; count unchanged.
  - div_wb_ready = rst_n && !flush && (count < DIV_Q_DEPTH). Ready is not raised by a same-cycle pop.
- rd==0 results consume the port slot, but wb_wr_en is forced 0 for that cycle.
- flush: the buffer is cleared at the next edge, a DIV handshake in the flush cycle is discarded, and no DIV result is written from the flush cycle onward. Fixed-unit results in the flush cycle are still written (upstream squashes them).
- Starvation FSM:
  - IDLE: buffer empty, counter 0. Go to WAIT on a push.
  - WAIT: counter increments each cycle the head is not popped. Head popped and buffer then empty -> IDLE. Counter reaches STARVE_LIMIT -> FORCE.
  - FORCE: ix_wb_stall=1 (registered). Exit on the cycle the head is popped: to WAIT with counter 0 if entries remain, else IDLE.
  - flush from any state -> IDLE, counter 0, ix_wb_stall=0 next cycle.
  - The counter resets to 0 on every pop.
- Stall assertion does not drain in-flight fixed-latency ops. A free slot appears at most MUL latency (3) cycles after the bubble, so FORCE is bounded.

Test Plan:
- Single ALU: alu_wb_valid, rd=5, data=0x1234 at cycle 0 -> cycle 1 wb_wr_en=1, wb_rd=5, wb_data=0x1234; cycle 2 wb_wr_en=0.
- DIV bypass: idle port, div valid rd=7, data=0xA at cycle 0 -> ready=1, cycle 1 writes rd 7 = 0xA, div_q_count stays 0.
- DIV vs MUL: MUL rd=3 and DIV rd=4 valid at cycle 0 -> cycle 1 writes rd 3, div_q_count=1; cycle 2 writes rd 4, count=0.
- Starvation: STARVE_LIMIT=4, one DIV buffered while ALU is valid every cycle -> ix_wb_stall=1 after 4 waiting cycles; on the first ALU-free cycle the DIV is written and ix_wb_stall drops the next cycle.
- Flush: two DIV entries buffered (ready=0), flush at cycle 0 -> cycle 1 count=0, ready=1, no DIV write ever appears; a concurrent ALU rd=2 is written at cycle 1.
- Collision and x0: ALU rd=1 with LSU rd=9 -> LSU written, collision_err=1 held through 10 idle cycles until rst_n=0; ALU rd=0 -> wb_wr_en=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter: schedules the register-file write port among ALU/LSU/MUL/DIV
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
  parameter int REG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int DIV_Q_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           alu_wb_valid,
  input  logic [REG_WIDTH-1:0]           alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]          alu_wb_data,
  input  logic                           lsu_wb_valid,
  input  logic [REG_WIDTH-1:0]           lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]          lsu_wb_data,
  input  logic                           mul_wb_valid,
  input  logic [REG_WIDTH-1:0]           mul_wb_rd,
  input  logic [DATA_WIDTH-1:0]          mul_wb_data,
  input  logic                           div_wb_valid,
  output logic                           div_wb_ready,
  input  logic [REG_WIDTH-1:0]           div_wb_rd,
  input  logic [DATA_WIDTH-1:0]          div_wb_data,
  output logic                           wb_wr_en,
  output logic [REG_WIDTH-1:0]           wb_rd,
  output logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           ix_wb_stall,
  output logic                           collision_err,
  output logic [$clog2(DIV_Q_DEPTH):0]   div_q_count
);

  localparam int PTR_W = $clog2(DIV_Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic                  fixed_any;
  logic                  collision_hit;
  logic                  q_empty;
  logic                  div_acc;
  logic                  slot_free;
  logic                  div_pop;
  logic                  div_bypass;
  logic                  div_push;

  logic                  win_valid;
  logic [REG_WIDTH-1:0]  win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  logic                  wb_wr_en_q, wb_wr_en_d;
  logic [REG_WIDTH-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  collision_q, collision_d;

  logic [REG_WIDTH-1:0]  mem_rd_q   [DIV_Q_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DIV_Q_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [1:0]            state_q, state_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic [STV_W-1:0]      starve_inc;

  assign fixed_any     = alu_wb_valid | lsu_wb_valid | mul_wb_valid;
  assign collision_hit = (alu_wb_valid & lsu_wb_valid) |
                         (alu_wb_valid & mul_wb_valid) |
                         (lsu_wb_valid & mul_wb_valid);
  assign q_empty       = (count_q == '0);

  // Ready deliberately ignores a same-cycle pop to keep it off the winner path.
  assign div_wb_ready  = rst_n && !flush && (count_q < CNT_W'(DIV_Q_DEPTH));
  assign div_acc       = div_wb_valid && div_wb_ready;
  assign slot_free     = !fixed_any && !flush;
  assign div_pop       = slot_free && !q_empty;
  assign div_bypass    = slot_free && q_empty && div_acc;
  assign div_push      = div_acc && !div_bypass;

  always_comb begin
    win_valid = 1'b0;
    win_rd    = '0;
    win_data  = '0;
    if (mul_wb_valid) begin
      win_valid = 1'b1;
      win_rd    = mul_wb_rd;
      win_data  = mul_wb_data;
    end else if (lsu_wb_valid) begin
      win_valid = 1'b1;
      win_rd    = lsu_wb_rd;
      win_data  = lsu_wb_data;
    end else if (alu_wb_valid) begin
      win_valid = 1'b1;
      win_rd    = alu_wb_rd;
      win_data  = alu_wb_data;
    end else if (div_pop) begin
      win_valid = 1'b1;
      win_rd    = mem_rd_q[head_q];
      win_data  = mem_data_q[head_q];
    end else if (div_bypass) begin
      win_valid = 1'b1;
      win_rd    = div_wb_rd;
      win_data  = div_wb_data;
    end
  end

  // x0 still consumes the slot; only the enable is suppressed.
  always_comb begin
    wb_wr_en_d  = win_valid && (win_rd != '0);
    wb_rd_d     = win_valid ? win_rd : wb_rd_q;
    wb_data_d   = win_valid ? win_data : wb_data_q;
    collision_d = collision_q | collision_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_wr_en_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      collision_q <= 1'b0;
    end else begin
      wb_wr_en_q  <= wb_wr_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      collision_q <= collision_d;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (div_pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (div_push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      case ({div_push, div_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (div_push) begin
      mem_rd_q[tail_q]   <= div_wb_rd;
      mem_data_q[tail_q] <= div_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign starve_inc = starve_q + STV_W'(1);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (flush) begin
      state_d  = ST_IDLE;
      starve_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          starve_d = '0;
          if (div_push) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_pop) begin
            starve_d = '0;
            if (count_d == '0) begin
              state_d = ST_IDLE;
            end
          end else begin
            starve_d = starve_inc;
            if (starve_inc >= STV_W'(STARVE_LIMIT)) begin
              state_d = ST_FORCE;
            end
          end
        end
        ST_FORCE: begin
          if (div_pop) begin
            starve_d = '0;
            state_d  = (count_d == '0) ? ST_IDLE : ST_WAIT;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          starve_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ix_wb_stall = (state_q == ST_FORCE);
  end

  assign wb_wr_en      = wb_wr_en_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign collision_err = collision_q;
  assign div_q_count   = count_q;

endmodule

`default_nettype wire
